ghash_mul_ctrl: RTL and testbench
=================================

GHASH_MUL_CTRL -- requirements
Module: ghash_mul_ctrl

Interface
REQ-001 SHALL provide parameter: MUL_LAT, default 1, cycles from mul_a/mul_b change to valid mul_p (legal 0..7).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: h_key  input  128  hash subkey H.
REQ-005 SHALL have port: h_load  input  1  load h_key into H and clear accumulator Y.
REQ-006 SHALL have ports: in_valid  input  1;  in_data  input  128;  in_last  input  1;  in_ready  output  1  (block input handshake).
REQ-007 SHALL have ports: mul_a  output  128;  mul_b  output  128;  mul_p  input  256  (external 128x128 carry-less multiplier, product bit i = coefficient of x^i).
REQ-008 SHALL have ports: out_valid  output  1;  out_tag  output  128;  out_ready  input  1  (tag output handshake).
REQ-009 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, MUL, OUT.
REQ-011 in_ready SHALL equal (state==IDLE) && !h_load, combinationally.
REQ-012 In IDLE with h_load=1: H <= h_key, Y <= 0, state stays IDLE; h_load outside IDLE SHALL be ignored.
REQ-013 In IDLE on in_valid && in_ready: mul_a <= Y ^ in_data, mul_b <= H, last flag <= in_last, wait counter <= 0, state -> MUL.
REQ-014 mul_a/mul_b SHALL remain stable throughout MUL and hold their last values in IDLE/OUT.
REQ-015 MUL SHALL last exactly MUL_LAT+1 cycles; on its final cycle Y <= reduce(mul_p).
REQ-016 reduce() SHALL be mod x^128 + x^7 + x^2 + x + 1 (bit i = coefficient of x^i), fully combinational, no extra cycle.
REQ-017 From MUL final cycle: state -> OUT if last flag set, else -> IDLE.
REQ-018 In OUT: out_valid=1, out_tag=Y; out_tag SHALL stay stable while out_valid && !out_ready.
REQ-019 On out_valid && out_ready: Y <= 0, state -> IDLE (H retained).
REQ-020 Block throughput SHALL be one block per MUL_LAT+2 cycles with in_valid held high; no block SHALL be accepted in MUL or OUT.
REQ-021 in_data SHALL be ignored when in_ready=0; in_last SHALL be sampled only on acceptance.

Reset
REQ-022 rst_n=0 SHALL asynchronously force state=IDLE, H=0, Y=0, mul_a=0, mul_b=0, last flag=0, wait counter=0.
REQ-023 Reset outputs: in_ready=1 (h_load low), out_valid=0, out_tag=0, busy=0, mul_a=0, mul_b=0.
REQ-024 Reset mid-MUL or mid-OUT SHALL abandon the operation; no tag SHALL be emitted afterwards for it.

Configuration
REQ-025 Macro GHASH_MUL_CTRL_CNT_EN defined: add port blk_cnt  output  32  blocks accepted since reset/h_load/tag handoff; increments on each in_valid && in_ready, wraps 0xFFFFFFFF -> 0, cleared by rst_n, h_load, and out handshake.
REQ-026 Macro undefined: no blk_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-027 MUL_LAT=1, h_load H=1, block 10 with last -> out_valid 3 cycles after acceptance, out_tag=10.
REQ-028 H=2, blocks 1 then 1 (last on second) -> tag=6; second in_ready rises exactly MUL_LAT+2 cycles after first acceptance.
REQ-029 H=2^127, block 2^127 last (mul_p=2^254) -> out_tag=0xC0000000_00000000_00000000_00001067.
REQ-030 Tag pending, out_ready=0 for 5 cycles -> out_valid and out_tag held, in_ready=0; out_ready=1 -> IDLE, next block with Y=0.
REQ-031 rst_n pulsed low during MUL -> immediate IDLE, out_valid=0, H=0; following block 5 with H reloaded to 1 -> tag=5.
REQ-032 With GHASH_MUL_CTRL_CNT_EN: 3 blocks accepted -> blk_cnt=3, then 0 after tag handshake.

Source files
------------

// File: rtl/ghash_mul_ctrl.sv
// ghash_mul_ctrl
// ----------------------------------------------------------------------------
// Sequencer for GHASH over GF(2^128) built around an external 128x128
// carry-less multiplier. For every accepted 128-bit block X it computes
//   Y <= reduce((Y ^ X) * H)
// with the field polynomial x^128 + x^7 + x^2 + x + 1. Bit i of every vector
// is the coefficient of x^i. When the block flagged as last has been folded
// in, Y is presented as the tag and held until the consumer takes it.
//
// Parameters
//   MUL_LAT  cycles from a change of mul_a/mul_b until mul_p is valid (0..7)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   h_key      hash subkey H
//   h_load     in IDLE: load h_key into H and clear Y (ignored otherwise)
//   in_valid   block input handshake: valid
//   in_data    block input data
//   in_last    block is the final block of the message (sampled on accept)
//   in_ready   block input handshake: ready (IDLE and no h_load)
//   mul_a      multiplier operand A (Y ^ X), stable for the whole MUL phase
//   mul_b      multiplier operand B (H)
//   mul_p      256-bit carry-less product from the external multiplier
//   out_valid  tag output handshake: valid
//   out_tag    tag value (Y), zero when no tag is pending
//   out_ready  tag output handshake: ready
//   busy       high whenever the controller is not IDLE
//   blk_cnt    blocks accepted since reset / h_load / tag handoff
//              (only with GHASH_MUL_CTRL_CNT_EN defined)
//
// Configuration macro
//   GHASH_MUL_CTRL_CNT_EN  adds the blk_cnt port and its 32-bit counter
// ----------------------------------------------------------------------------
module ghash_mul_ctrl #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] h_key,
  input  logic         h_load,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic [127:0] mul_a,
  output logic [127:0] mul_b,
  input  logic [255:0] mul_p,
  output logic         out_valid,
  output logic [127:0] out_tag,
  input  logic         out_ready,
  output logic         busy
`ifdef GHASH_MUL_CTRL_CNT_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Final value of the wait counter: MUL spans MUL_LAT+1 cycles, the counter
  // starts at 0 on entry, so the product is valid when it reaches MUL_LAT.
  localparam logic [2:0] LAT_LAST = 3'(MUL_LAT);

  state_t       state;
  state_t       state_nxt;
  logic [127:0] h_q;
  logic [127:0] y_q;
  logic         last_q;
  logic [2:0]   wait_cnt;

  logic         accept;
  logic         mul_done;
  logic         out_fire;

  // --------------------------------------------------------------------------
  // Reduction of a 256-bit carry-less product modulo x^128+x^7+x^2+x+1.
  // Each set bit x^i with i >= 128 is replaced by
  // x^(i-128) * (x^7 + x^2 + x + 1). Walking from the top down guarantees
  // that bits folded into lower positions above 127 are themselves reduced
  // later in the same pass. Pure combinational logic.
  // --------------------------------------------------------------------------
  function automatic logic [127:0] gf_reduce(input logic [255:0] p);
    logic [255:0] r;
    r = p;
    for (int i = 255; i >= 128; i--) begin
      if (r[i]) begin
        r[i]       = 1'b0;
        r[i - 121] = ~r[i - 121];
        r[i - 126] = ~r[i - 126];
        r[i - 127] = ~r[i - 127];
        r[i - 128] = ~r[i - 128];
      end
    end
    return r[127:0];
  endfunction

  assign accept   = in_valid && in_ready;
  assign mul_done = (state == MUL) && (wait_cnt == LAT_LAST);
  assign out_fire = out_valid && out_ready;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // NOTE: the reset is in the sensitivity list, so asserting rst_n low takes
  // effect immediately and abandons any block or tag in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  // NOTE: state_nxt is given a default before the case statement so every
  // path assigns it and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)    state_nxt = MUL;
      MUL:  if (mul_done)  state_nxt = last_q ? OUT : IDLE;
      OUT:  if (out_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state == IDLE) && !h_load;
    out_valid = (state == OUT);
    busy      = (state != IDLE);
    // Y is only published while a tag is pending; intermediate chaining
    // values stay internal.
    out_tag   = (state == OUT) ? y_q : '0;
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would let later statements see
  // values already updated in this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q      <= '0;
      y_q      <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      last_q   <= 1'b0;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (h_load) begin
            // New key starts a fresh hash; h_load masks in_ready so no
            // block can be accepted in the same cycle.
            h_q <= h_key;
            y_q <= '0;
          end else if (in_valid) begin
            // in_ready is 1 here (IDLE, no h_load), so this is an accept.
            mul_a    <= y_q ^ in_data;
            mul_b    <= h_q;
            last_q   <= in_last;
            wait_cnt <= '0;
          end
        end
        MUL: begin
          // Operands are left untouched so the external multiplier sees
          // stable inputs for the full latency.
          if (mul_done) begin
            y_q <= gf_reduce(mul_p);
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            // Tag handed off: next message starts from Y = 0, H retained.
            y_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GHASH_MUL_CTRL_CNT_EN
  // --------------------------------------------------------------------------
  // Accepted-block counter; wraps naturally at 2^32.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
    end else if (((state == IDLE) && h_load) || out_fire) begin
      blk_cnt <= '0;
    end else if (accept) begin
      blk_cnt <= blk_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ghash_mul_ctrl.sv
// Directed testbench for ghash_mul_ctrl (MUL_LAT = 1).
// The external multiplier is modelled as a carry-less multiply registered
// once, so mul_p becomes valid exactly MUL_LAT cycles after the operands.
// Outputs are sampled 1 ns after the rising edge; inputs are driven there too.
module tb_ghash_mul_ctrl;

  localparam int unsigned MUL_LAT = 1;

  logic         clk;
  logic         rst_n;
  logic [127:0] h_key;
  logic         h_load;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_last;
  logic         in_ready;
  logic [127:0] mul_a;
  logic [127:0] mul_b;
  logic [255:0] mul_p;
  logic         out_valid;
  logic [127:0] out_tag;
  logic         out_ready;
  logic         busy;
`ifdef GHASH_MUL_CTRL_CNT_EN
  logic [31:0]  blk_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [127:0] top_bit;

  ghash_mul_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .h_key     (h_key),
    .h_load    (h_load),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_tag   (out_tag),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef GHASH_MUL_CTRL_CNT_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry-less 128x128 multiply: reference for the external multiplier.
  function automatic logic [255:0] clmul(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] p;
    p = '0;
    for (int i = 0; i < 128; i++) begin
      if (b[i]) p = p ^ ({128'b0, a} << i);
    end
    return p;
  endfunction

  // One pipeline stage = MUL_LAT of 1.
  always @(posedge clk) mul_p <= clmul(mul_a, mul_b);

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one block while IDLE, then wait out the MUL phase.
  task automatic send_block(input logic [127:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (MUL_LAT + 1) tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    h_key     = '0;
    h_load    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    top_bit   = 128'h80000000_00000000_00000000_00000000;

    // ---- reset state ----
    #1;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_tag",   out_tag,   0);
    check("rst_busy",      busy,      0);
    check("rst_mul_a",     mul_a,     0);
    check("rst_mul_b",     mul_b,     0);
`ifdef GHASH_MUL_CTRL_CNT_EN
    check("rst_blk_cnt",   blk_cnt,   0);
`endif
    #20 rst_n = 1'b1;
    tick();

    // ---- H=1, single block 10 with last: tag 3 cycles after acceptance ----
    h_key  = 128'd1;
    h_load = 1'b1;
    #1 check("hload_blocks_ready", in_ready, 0);
    tick();
    h_load   = 1'b0;
    in_valid = 1'b1;
    in_data  = 128'd10;
    in_last  = 1'b1;
    #1 check("idle_ready", in_ready, 1);
    tick();                                    // accepted; cycle +1
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("mul_busy",     busy,     1);
    check("mul_ready",    in_ready, 0);
    check("mul_a_10",     mul_a,    10);
    check("mul_b_h1",     mul_b,    1);
    tick();                                    // cycle +2
    check("no_early_tag", out_valid, 0);
    tick();                                    // cycle +3
    check("tag10_valid",  out_valid, 1);
    check("tag10_value",  out_tag,   10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("tag10_done_valid", out_valid, 0);
    check("tag10_done_busy",  busy,      0);

    // ---- H=2, blocks 1,1: tag 6, throughput MUL_LAT+2 ----
    h_key  = 128'd2;
    h_load = 1'b1;
    tick();
    h_load   = 1'b0;
    in_valid = 1'b1;
    in_data  = 128'd1;
    in_last  = 1'b0;
    tick();                                    // accepted; cycle +1
    in_data  = '1;                             // must be ignored while not ready
    in_last  = 1'b1;
    check("thr_ready_c1", in_ready, 0);
    tick();                                    // cycle +2
    check("thr_ready_c2", in_ready, 0);
    tick();                                    // cycle +3 = MUL_LAT+2
    check("thr_ready_c3", in_ready, 1);
    in_data = 128'd1;
    tick();                                    // second block accepted
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("chain_mul_a", mul_a, 3);
    check("chain_mul_b", mul_b, 2);
    repeat (MUL_LAT + 1) tick();
    check("tag6_valid", out_valid, 1);
    check("tag6_value", out_tag,   6);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // ---- H=x^127, block x^127: reduction of x^254 ----
    h_key  = top_bit;
    h_load = 1'b1;
    tick();
    h_load = 1'b0;
    send_block(top_bit, 1'b1);
    check("red_valid", out_valid, 1);
    check("red_value", out_tag, 128'hC0000000_00000000_00000000_00001067);

    // ---- back-pressure: tag held 5 cycles, inputs and h_load ignored ----
    in_valid = 1'b1;
    in_data  = 128'd5;
    h_key    = 128'hAB;
    h_load   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_tag",   out_tag,   128'hC0000000_00000000_00000000_00001067);
      check("hold_ready", in_ready,  0);
    end
    h_load    = 1'b0;
    out_ready = 1'b1;
    in_data   = 128'd7;
    in_last   = 1'b1;
    tick();                                    // handshake done, IDLE
    out_ready = 1'b0;
    check("post_tag_valid", out_valid, 0);
    check("post_tag_ready", in_ready,  1);
    tick();                                    // block 7 accepted
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("y_cleared_mul_a", mul_a, 7);
    check("h_kept_mul_b",    mul_b, top_bit);
    repeat (MUL_LAT + 1) tick();
    check("tag7_value", out_tag, 128'h80000000_00000000_00000000_00000189);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // ---- reset during MUL abandons the block and clears H ----
    in_valid = 1'b1;
    in_data  = 128'd9;
    in_last  = 1'b1;
    tick();                                    // accepted, in MUL
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",      busy,      0);
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready",  in_ready,  1);
    check("arst_mul_a",     mul_a,     0);
    check("arst_mul_b",     mul_b,     0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_stale_tag", out_valid, 0);
    end
    send_block(128'd3, 1'b1);                  // H is 0 after reset
    check("h0_valid", out_valid, 1);
    check("h0_tag",   out_tag,   0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    h_key  = 128'd1;
    h_load = 1'b1;
    tick();
    h_load = 1'b0;
    send_block(128'd5, 1'b1);
    check("tag5_value", out_tag, 5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // ---- three blocks 1,2,4 with H=1: tag 7, block counter ----
    h_key  = 128'd1;
    h_load = 1'b1;
    tick();
    h_load = 1'b0;
`ifdef GHASH_MUL_CTRL_CNT_EN
    check("cnt_after_load", blk_cnt, 0);
`endif
    send_block(128'd1, 1'b0);
    send_block(128'd2, 1'b0);
    send_block(128'd4, 1'b1);
    check("tag_xor_value", out_tag, 7);
`ifdef GHASH_MUL_CTRL_CNT_EN
    check("cnt_three", blk_cnt, 3);
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("final_idle", busy, 0);
`ifdef GHASH_MUL_CTRL_CNT_EN
    check("cnt_cleared", blk_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
